// File: rtl/vga_sync_core.sv
// VGA output stage: regenerates HSYNC/VSYNC from the frame counter coordinates, delayed to match the pixel pipeline.
// It also blanks pixels outside the active area and exposes a force-blank control and a 16-bit frame counter.
module vga_sync_core #(
    parameter int PIPE_DLY = 2,
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [13:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [11:0] si_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam logic [10:0] H_DISP_C  = 11'(H_DISP);
    localparam logic [10:0] HS_FIRST  = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_LAST   = 11'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_TOTAL_C = 11'(H_DISP + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_DISP_C  = 11'(V_DISP);
    localparam logic [10:0] VS_FIRST  = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_LAST   = 11'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_TOTAL_C = 11'(V_DISP + V_FP + V_SYNC + V_BP);

    // Delay-line fill value: {h, v, von} = syncs inactive, video off
    localparam logic [2:0] FILL = 3'b110;

    logic        in_range;
    logic        h_raw;
    logic        v_raw;
    logic        von_raw;
    logic        frame_end;
    logic [2:0]  dly [PIPE_DLY];
    logic        blank;
    logic [15:0] frame_cnt;
    logic        unused_bits;

    assign unused_bits = &{1'b0, read, wr_data[31:1], addr[13:2]};

    always_comb begin
        in_range  = (x < H_TOTAL_C) && (y < V_TOTAL_C);
        h_raw     = !(in_range && (x >= HS_FIRST) && (x <= HS_LAST));
        v_raw     = !(in_range && (y >= VS_FIRST) && (y <= VS_LAST));
        von_raw   = in_range && (x < H_DISP_C) && (y < V_DISP_C);
        frame_end = (x == H_TOTAL_C - 11'd1) && (y == V_TOTAL_C - 11'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                dly[i] <= FILL;
            end
        end else begin
            dly[0] <= {h_raw, v_raw, von_raw};
            for (int i = 1; i < PIPE_DLY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Pins are registered; blank takes effect from the edge after it is written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 12'h000;
        end else begin
            hsync <= dly[PIPE_DLY-1][2];
            vsync <= dly[PIPE_DLY-1][1];
            rgb   <= (dly[PIPE_DLY-1][0] && !blank) ? si_rgb : 12'h000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank     <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            if (cs && write && (addr[1:0] == 2'd0)) begin
                blank <= wr_data[0];
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (addr[1:0])
            2'd0:    rd_data = {31'b0, blank};
            2'd1:    rd_data = {16'b0, frame_cnt};
            default: rd_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_vga_sync_core.sv
// Self-checking bench for vga_sync_core: register vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based timing model built from the 640x480 rules.
module tb_vga_sync_core;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic [11:0] si_rgb = '0;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    vga_sync_core #(.PIPE_DLY(D)) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic h;
        logic v;
        logic von;
    } raw_t;

    raw_t        hist[$];
    logic        blank_m = 1'b0;
    logic [15:0] cnt_m = 16'h0;

    function automatic raw_t raw_of(input int xx, input int yy);
        raw_t r;
        r.h = 1'b1; r.v = 1'b1; r.von = 1'b0;
        if (xx < 800 && yy < 525) begin
            r.h   = !(xx >= 656 && xx <= 751);
            r.v   = !(yy >= 490 && yy <= 491);
            r.von = (xx < 640) && (yy < 480);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [13:0] a);
        case (a[1:0])
            2'd0:    return {31'b0, blank_m};
            2'd1:    return {16'b0, cnt_m};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        blank_m = 1'b0;
        cnt_m   = 16'h0;
    endtask

    // One clock cycle: drive inputs, check rd_data pre-edge, clock, check pins against the model
    task automatic step(input int xx, input int yy, input logic [11:0] si, input logic c,
                        input logic w, input logic r, input logic [13:0] a, input logic [31:0] wd);
        logic        eh, ev;
        logic [11:0] ergb;
        x = 11'(xx); y = 11'(yy); si_rgb = si; cs = c; write = w; read = r; addr = a; wr_data = wd;
        #1;
        check("rd_pre_edge", rd_data, exp_rd(a));
        @(posedge clk);
        eh = 1'b1; ev = 1'b1; ergb = 12'h000;
        if (hist.size() >= D) begin
            eh = hist[0].h;
            ev = hist[0].v;
            ergb = (hist[0].von && !blank_m) ? si : 12'h000;
        end
        hist.push_back(raw_of(xx, yy));
        if (hist.size() > D) void'(hist.pop_front());
        if (c && w && a[1:0] == 2'd0) blank_m = wd[0];
        if (xx == 799 && yy == 524) cnt_m = cnt_m + 16'd1;
        #1;
        check("hsync", hsync, eh);
        check("vsync", vsync, ev);
        check("rgb", rgb, ergb);
    endtask

    task automatic step_xy(input int xx, input int yy, input logic [11:0] si);
        step(xx, yy, si, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
    endtask

    typedef struct {
        logic        c;
        logic        w;
        logic [13:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl[9];

    initial begin
        int hs_low, first_hs, rgb_on, first_rgb, vs_low, first_vs;
        logic [11:0] si;

        tbl[0] = '{1'b1, 1'b1, 14'h0000, 32'h0000_0001, 32'h1};
        tbl[1] = '{1'b1, 1'b1, 14'h0001, 32'h0000_1234, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 14'h0000, 32'h0000_0000, 32'h1};
        tbl[3] = '{1'b1, 1'b0, 14'h0000, 32'h0000_0000, 32'h1};
        tbl[4] = '{1'b1, 1'b1, 14'h3FFC, 32'hFFFF_FFFE, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 14'h0002, 32'hFFFF_FFFF, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 14'h0003, 32'hFFFF_FFFF, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 14'h2000, 32'h0000_0003, 32'h1};
        tbl[8] = '{1'b1, 1'b1, 14'h0000, 32'h0000_0000, 32'h0};

        // Reset held while coordinates sweep
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = 11'($urandom_range(0, 799));
            y = 11'($urandom_range(0, 524));
            si_rgb = 12'($urandom);
            addr = 14'd1;
            @(posedge clk);
            #1;
            check("rst_hsync", hsync, 1'b1);
            check("rst_vsync", vsync, 1'b1);
            check("rst_rgb", rgb, 12'h000);
            check("rst_frame_cnt", rd_data, 32'h0);
        end
        #1 reset_n = 1'b1;
        model_reset();

        // Release: fill values persist until the first sampled x/y reaches the pins
        step(700, 491, 12'hFFF, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
        check("fill0_hsync", hsync, 1'b1);
        check("fill0_rgb", rgb, 12'h000);
        step(700, 491, 12'hFFF, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
        check("fill1_hsync", hsync, 1'b1);
        check("fill1_vsync", vsync, 1'b1);
        step(700, 491, 12'hFFF, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
        check("lat3_hsync", hsync, 1'b0);
        check("lat3_vsync", vsync, 1'b0);

        for (int i = 0; i < 9; i++) begin
            step(645, 300, 12'h111, tbl[i].c, tbl[i].w, 1'b1, tbl[i].a, tbl[i].wd);
            check("reg_tbl", rd_data, tbl[i].exp);
        end
        step_xy(645, 300, 12'h111);
        step_xy(645, 300, 12'h111);

        // Hsync window and active pixels over one line
        hs_low = 0; first_hs = -1; rgb_on = 0; first_rgb = -1;
        for (int i = 0; i < 803; i++) begin
            if (i < 800) step_xy(i, 100, 12'hABC);
            else         step_xy(i - 800, 480, 12'hABC);
            if (hsync == 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = i;
            end
            if (rgb == 12'hABC) begin
                rgb_on++;
                if (first_rgb < 0) first_rgb = i;
            end
        end
        check("hs_low_cycles", 32'(hs_low), 32'd96);
        check("hs_first_step", 32'(first_hs), 32'd658);
        check("rgb_on_cycles", 32'(rgb_on), 32'd640);
        check("rgb_first_step", 32'(first_rgb), 32'd2);

        // Vsync window across the lines around the sync pulse
        vs_low = 0; first_vs = -1;
        for (int i = 0; i < 3203; i++) begin
            if (i < 3200) step_xy(i % 800, 489 + i / 800, 12'h0F0);
            else          step_xy(i - 3200, 493, 12'h0F0);
            if (vsync == 1'b0) begin
                vs_low++;
                if (first_vs < 0) first_vs = i;
            end
        end
        check("vs_low_cycles", 32'(vs_low), 32'd1600);
        check("vs_first_step", 32'(first_vs), 32'd802);

        // Frame counter increments, write protection
        step(799, 524, 12'h0, 1'b1, 1'b0, 1'b1, 14'd1, 32'h0);
        check("fc_inc1", rd_data, 32'd1);
        step(799, 524, 12'h0, 1'b1, 1'b0, 1'b1, 14'd1, 32'h0);
        check("fc_inc2", rd_data, 32'd2);
        step(10, 10, 12'h0, 1'b1, 1'b1, 1'b0, 14'd1, 32'h0000_1234);
        check("fc_write_ignored", rd_data, 32'd2);

        // Force blank mid-line
        for (int i = 0; i < 20; i++) begin
            si = 12'h800 | 12'($urandom_range(0, 2047));
            if (i == 8)       step(200 + i, 100, si, 1'b1, 1'b1, 1'b0, 14'd0, 32'h1);
            else if (i == 14) step(200 + i, 100, si, 1'b1, 1'b1, 1'b0, 14'd0, 32'h0);
            else              step(200 + i, 100, si, 1'b0, 1'b0, 1'b1, 14'd0, 32'h0);
            if (i == 8)  check("blank_edge_n_rgb", rgb, si);
            if (i == 9)  check("blank_edge_n1_rgb", rgb, 12'h000);
            if (i == 10) check("blank_readback", rd_data, 32'h1);
            if (i == 14) check("unblank_edge_n_rgb", rgb, 12'h000);
            if (i == 15) check("unblank_edge_n1_rgb", rgb, si);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int xx, yy;
            xx = $urandom_range(0, 849);
            yy = $urandom_range(0, 549);
            if ($urandom_range(0, 15) == 0) begin xx = 799; yy = 524; end
            step(xx, yy, 12'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 14'($urandom), $urandom);
        end

        // Wrap: bring the count to 16'hFFFF, then one more frame end
        step(10, 10, 12'h0, 1'b1, 1'b1, 1'b0, 14'd0, 32'h0);
        while (cnt_m != 16'hFFFF) begin
            step(799, 524, 12'h0, 1'b0, 1'b0, 1'b1, 14'd1, 32'h0);
        end
        check("fc_at_ffff", rd_data, 32'h0000_FFFF);
        step(799, 524, 12'h0, 1'b0, 1'b0, 1'b1, 14'd1, 32'h0);
        check("fc_wrap", rd_data, 32'h0);

        // Async reset during active video with a nonzero pixel
        for (int i = 0; i < 4; i++) step_xy(100 + i, 100, 12'hABC);
        check("pre_rst_rgb", rgb, 12'hABC);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rgb", rgb, 12'h000);
        check("async_rst_hsync", hsync, 1'b1);
        check("async_rst_vsync", vsync, 1'b1);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Async reset while syncs are low and blank is set
        step(700, 491, 12'h0, 1'b1, 1'b1, 1'b0, 14'd0, 32'h1);
        for (int i = 0; i < 4; i++) step(700, 491, 12'h0, 1'b0, 1'b0, 1'b0, 14'd0, 32'h0);
        check("pre_rst_hsync", hsync, 1'b0);
        addr = 14'd0;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_hsync2", hsync, 1'b1);
        check("async_rst_vsync2", vsync, 1'b1);
        check("async_rst_blank", rd_data, 32'h0);
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step_xy(50 + i, 60, 12'h5A5);
        check("post_rst_rgb", rgb, 12'h5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
